dac_word_capture: RTL and testbench
===================================

// Module: dac_word_capture
// PURPOSE
//  Receive-side monitor for the decimated amplifier-drive DAC bus (13-bit word + DAC_en strobe).
//  Latches each word on the DAC_en rising edge while a store-strobe window is open and buffers
//  it in block RAM. Detects the trailing clear/zero strobe, then offers the captured pulse for
//  word-by-word readout. Sits beside the feed-forward output path for loopback/diagnostic checks.
// PARAMETERS
//  DEPTH_LOG2  8   log2 of capture buffer depth (256 words)
//  DWIDTH      13  DAC word width, two's complement
// PORTS
//  clk            in   1           system clock (same domain as DAC drive logic)
//  rst            in   1           synchronous, active-high reset
//  arm            in   1           single-cycle pulse; arms capture for the next store_strb window
//  store_strb     in   1           capture window (high for whole pulse)
//  dac_en_in      in   1           DAC clock/enable as driven to the DAC pins
//  dac_data_in    in   DWIDTH      DAC data word as driven to the DAC pins
//  rd_req         in   1           readout request, one word per asserted cycle
//  rd_data        out  DWIDTH      readout word
//  rd_valid       out  1           rd_data valid (1 cycle after accepted rd_req)
//  word_count     out  DEPTH_LOG2+1 words stored in last capture
//  done           out  1           capture complete, data available for readout
//  clear_seen     out  1           trailing zero/clear strobe detected after window close
//  overrun        out  1           more words arrived than DEPTH; excess discarded
//  sat_count      out  DEPTH_LOG2+1 full-scale words in last capture (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM -> IDLE; write/read pointers 0. Reset mid-capture/readout aborts it.
//  - Inputs dac_en_in, dac_data_in, store_strb registered once on entry (1-cycle input latency).
//  - Edge: word strobe = dac_en_r & ~dac_en_rr; data sampled from the same registered stage.
//  - FSM IDLE: wait arm -> ARMED; arm also clears word_count, sat_count, overrun, clear_seen, done.
//  - ARMED: on store_strb_r rising edge -> CAPTURE. arm re-pulse here is a no-op.
//  - CAPTURE: each word strobe with store_strb_r=1 writes RAM[wr_ptr], wr_ptr++, word_count++.
//    wr_ptr == 2^DEPTH_LOG2: write suppressed, overrun<=1, word_count saturates at 2^DEPTH_LOG2.
//    store_strb_r falling -> FLUSH; a strobe coincident with the falling edge is still stored.
//  - FLUSH: strobe with data==0 within 8 cycles -> clear_seen<=1, word not stored; either way
//    after clear strobe or 8-cycle timeout -> DONE. done<=1 on DONE entry.
//  - DONE: rd_req with rd_ptr<word_count -> RAM read; rd_data/rd_valid next cycle; rd_ptr++.
//    rd_req with rd_ptr==word_count ignored (rd_valid stays 0). Last word read -> IDLE, done<=0.
//    arm in DONE discards remaining data and re-arms (-> ARMED, counters cleared).
//  - rd_data holds last read value between reads; rd_valid is a single-cycle pulse per word.
//  - word_count/overrun/clear_seen hold value through IDLE until next arm.
//  - arm in CAPTURE/FLUSH ignored. store_strb in IDLE/DONE ignored.
// CONFIGURATION
//  SAT_DETECT_EN defined: each stored word equal to +4095 or -4096 increments sat_count
//   (saturating at 2^DEPTH_LOG2); cleared on arm.
//  SAT_DETECT_EN undefined: sat_count tied to 0; no comparator logic synthesised.
// TESTING
//  1. rst, arm, store_strb high 40 cycles, dac_en toggling /2 with data 1..20 -> word_count=20,
//     readout returns 1..20 in order, each with 1-cycle rd_valid.
//  2. After window close, one strobe with data 0 at +3 cycles -> clear_seen=1, word_count unchanged.
//  3. No trailing strobe -> DONE after 8-cycle timeout, clear_seen=0, done=1.
//  4. 300 strobes in window (DEPTH 256) -> word_count=256, overrun=1, words 257..300 absent.
//  5. rst asserted mid-CAPTURE after 10 words -> all outputs 0, store_strb then ignored until arm.
//  6. SAT_DETECT_EN: words {4095,-4096,0,4094} -> sat_count=2; macro undefined -> sat_count=0.

Source files
------------

// File: rtl/dac_word_capture.sv
// rtl/dac_word_capture.sv - DAC bus word capture buffer with post-capture readout
// Optional feature macro: SAT_DETECT_EN (counts full-scale words on sat_count)
module dac_word_capture #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DWIDTH     = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  store_strb,
    input  logic                  dac_en_in,
    input  logic [DWIDTH-1:0]     dac_data_in,
    input  logic                  rd_req,
    output logic [DWIDTH-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  done,
    output logic                  clear_seen,
    output logic                  overrun,
    output logic [DEPTH_LOG2:0]   sat_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                en_r_q;
    logic                en_rr_q;
    logic                strb_r_q;
    logic                strb_rr_q;
    logic [DWIDTH-1:0]   data_r_q;
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic [DEPTH_LOG2:0] word_count_q;
    logic [2:0]          flush_cnt_q;
    logic [DWIDTH-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                done_q;
    logic                clear_seen_q;
    logic                overrun_q;
    logic [DWIDTH-1:0]   mem [DEPTH];

    logic word_strb;
    logic strb_rise;
    logic strb_fall;
    logic arm_clear_d;
    logic capture_d;
    logic wr_en_d;
    logic rd_en_d;

    // A strobe on the window's opening or closing edge still belongs to the pulse.
    always_comb begin
        word_strb   = en_r_q & ~en_rr_q;
        strb_rise   = strb_r_q & ~strb_rr_q;
        strb_fall   = ~strb_r_q & strb_rr_q;
        arm_clear_d = arm && (state_q == S_IDLE || state_q == S_DONE);
        capture_d   = 1'b0;
        if (word_strb) begin
            if (state_q == S_ARMED) begin
                capture_d = strb_rise;
            end else if (state_q == S_CAPTURE) begin
                capture_d = strb_r_q | strb_rr_q;
            end
        end
        wr_en_d = capture_d && (wr_ptr_q != FULL);
        rd_en_d = (state_q == S_DONE) && rd_req && !arm && (rd_ptr_q < word_count_q);
    end

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_r_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            en_r_q       <= 1'b0;
            en_rr_q      <= 1'b0;
            strb_r_q     <= 1'b0;
            strb_rr_q    <= 1'b0;
            data_r_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_count_q <= '0;
            flush_cnt_q  <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            clear_seen_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            en_r_q     <= dac_en_in;
            en_rr_q    <= en_r_q;
            strb_r_q   <= store_strb;
            strb_rr_q  <= strb_r_q;
            data_r_q   <= dac_data_in;
            rd_valid_q <= rd_en_d;
            if (rd_en_d) begin
                rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            if (wr_en_d) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                word_count_q <= word_count_q + 1'b1;
            end
            if (capture_d && !wr_en_d) begin
                overrun_q <= 1'b1;
            end
            if (arm_clear_d) begin
                state_q      <= S_ARMED;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                word_count_q <= '0;
                overrun_q    <= 1'b0;
                clear_seen_q <= 1'b0;
                done_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_ARMED: begin
                        if (strb_rise) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (strb_fall) begin
                            state_q     <= S_FLUSH;
                            flush_cnt_q <= '0;
                        end
                    end
                    S_FLUSH: begin
                        // Only a zero word counts as the trailing clear strobe; others are ignored.
                        if (word_strb && data_r_q == '0) begin
                            clear_seen_q <= 1'b1;
                            done_q       <= 1'b1;
                            state_q      <= S_DONE;
                        end else if (flush_cnt_q == 3'd7) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (rd_en_d && (rd_ptr_q + 1'b1 == word_count_q)) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SAT_DETECT_EN
    logic [DEPTH_LOG2:0] sat_count_q;
    logic                sat_hit_d;

    assign sat_hit_d = (data_r_q == {1'b0, {(DWIDTH-1){1'b1}}}) ||
                       (data_r_q == {1'b1, {(DWIDTH-1){1'b0}}});

    always_ff @(posedge clk) begin
        if (rst || arm_clear_d) begin
            sat_count_q <= '0;
        end else if (wr_en_d && sat_hit_d && sat_count_q != FULL) begin
            sat_count_q <= sat_count_q + 1'b1;
        end
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = '0;
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign word_count = word_count_q;
    assign done       = done_q;
    assign clear_seen = clear_seen_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dac_word_capture.sv
// tb/tb_dac_word_capture.sv - randomized bench for dac_word_capture against a window-rule model
module tb_dac_word_capture;
    localparam int DL    = 8;
    localparam int DW    = 13;
    localparam int DEPTH = 256;
    localparam int MAXC  = 1200;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          store_strb;
    logic          dac_en_in;
    logic [DW-1:0] dac_data_in;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [DL:0]   word_count;
    logic          done;
    logic          clear_seen;
    logic          overrun;
    logic [DL:0]   sat_count;

    always #5 clk = ~clk;

    dac_word_capture #(.DEPTH_LOG2(DL), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .store_strb(store_strb),
        .dac_en_in(dac_en_in), .dac_data_in(dac_data_in), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .word_count(word_count),
        .done(done), .clear_seen(clear_seen), .overrun(overrun), .sat_count(sat_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit            st_a  [MAXC];
    bit            en_a  [MAXC];
    bit            arm_a [MAXC];
    logic [DW-1:0] d_a   [MAXC];
    int            len;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    bit            exp_ovr;
    bit            exp_clr;
    int            exp_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit st, input bit en, input logic [DW-1:0] d);
        if (len < MAXC) begin
            st_a[len]  = st;
            en_a[len]  = en;
            d_a[len]   = d;
            arm_a[len] = 1'b0;
            len++;
        end
    endtask

    function automatic bit rise(input int k);
        if (k == 0) return en_a[0];
        return en_a[k] && !en_a[k-1];
    endfunction

    // Lead-in, window holding src_q words, closing edge, then a 14-cycle tail.
    task automatic build(input int hi_max, input int lo_max, input bit end_coinc,
                         input int zero_off, input bit noise, input bit arm_mid);
        int nsrc;
        int last;
        int r;
        int f;
        nsrc = src_q.size();
        len  = 0;
        push(0, 0, '0);
        push(0, 0, '0);
        r = len;
        push(1, 0, '0);
        last = (end_coinc && nsrc > 0) ? nsrc - 1 : nsrc;
        for (int i = 0; i < last; i++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, hi_max);
            lo = $urandom_range(1, lo_max);
            repeat (hi) push(1, 1, src_q[i]);
            repeat (lo) push(1, 0, src_q[i]);
        end
        f = len;
        if (last < nsrc) push(0, 1, src_q[last]);
        else push(0, 0, '0);
        for (int t = 1; t <= 14; t++) begin
            if (t == zero_off) push(0, 1, '0);
            else if (noise && t == zero_off - 2) push(0, 1, 13'd5);
            else push(0, 0, '0);
        end
        if (arm_mid && r + 3 < f) arm_a[r+3] = 1'b1;
    endtask

    // Words: enable rises from window open through the close cycle; clear: zero-word rise within 8 cycles after close.
    task automatic model();
        int r;
        int f;
        r = -1;
        f = -1;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_clr = 1'b0;
        exp_sat = 0;
        for (int k = 0; k < len; k++) begin
            if (st_a[k] && (k == 0 || !st_a[k-1])) begin
                r = k;
                break;
            end
        end
        if (r >= 0) begin
            for (int k = r + 1; k < len; k++) begin
                if (!st_a[k]) begin
                    f = k;
                    break;
                end
            end
        end
        if (r >= 0 && f >= 0) begin
            for (int k = r; k <= f; k++) begin
                if (rise(k)) begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(d_a[k]);
                        if (d_a[k] == 13'h0FFF || d_a[k] == 13'h1000) exp_sat++;
                    end else begin
                        exp_ovr = 1'b1;
                    end
                end
            end
            for (int k = f + 1; k <= f + 8 && k < len; k++) begin
                if (rise(k) && d_a[k] == '0) begin
                    exp_clr = 1'b1;
                    break;
                end
            end
        end
`ifndef SAT_DETECT_EN
        exp_sat = 0;
`endif
    endtask

    task automatic play(input int upto);
        for (int k = 0; k < upto; k++) begin
            store_strb  = st_a[k];
            dac_en_in   = en_a[k];
            dac_data_in = d_a[k];
            arm         = arm_a[k];
            step();
        end
        store_strb  = 1'b0;
        dac_en_in   = 1'b0;
        dac_data_in = '0;
        arm         = 1'b0;
    endtask

    task automatic capture(input string tag);
        arm = 1'b1;
        step();
        arm = 1'b0;
        model();
        play(len);
        for (int i = 0; i < 40 && !done; i++) step();
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".word_count"}, 32'(word_count), 32'(exp_q.size()));
        check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
        check({tag, ".clear_seen"}, 32'(clear_seen), 32'(exp_clr));
        check({tag, ".sat_count"}, 32'(sat_count), 32'(exp_sat));
    endtask

    task automatic readout(input string tag);
        int n;
        int got;
        int budget;
        n = exp_q.size();
        got = 0;
        budget = 0;
        if (n == 0) begin
            rd_req = 1'b1;
            step();
            rd_req = 1'b0;
            check({tag, ".empty_rd_valid"}, 32'(rd_valid), 32'd0);
            check({tag, ".empty_done"}, 32'(done), 32'd1);
            return;
        end
        while (got < n && budget < 4 * n + 40) begin
            rd_req = ($urandom_range(0, 3) != 0);
            step();
            budget++;
            if (rd_req) begin
                check({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
                check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q[got]));
                got++;
            end else begin
                check({tag, ".idle_rd_valid"}, 32'(rd_valid), 32'd0);
            end
        end
        rd_req = 1'b0;
        check({tag, ".words_read"}, 32'(got), 32'(n));
        check({tag, ".done_after_read"}, 32'(done), 32'd0);
        check({tag, ".count_held"}, 32'(word_count), 32'(n));
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check({tag, ".extra_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, ".rd_data_held"}, 32'(rd_data), 32'(exp_q[n-1]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_data"}, 32'(rd_data), 32'd0);
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, ".word_count"}, 32'(word_count), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".clear_seen"}, 32'(clear_seen), 32'd0);
        check({tag, ".overrun"}, 32'(overrun), 32'd0);
        check({tag, ".sat_count"}, 32'(sat_count), 32'd0);
    endtask

    task automatic seq_src(input int n);
        src_q.delete();
        for (int i = 1; i <= n; i++) src_q.push_back(DW'(i));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        store_strb = 1'b0;
        dac_en_in = 1'b0;
        dac_data_in = '0;
        rd_req = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        seq_src(20);
        build(1, 1, 0, 0, 0, 0);
        capture("t1");
        readout("t1");

        build(1, 1, 0, 3, 0, 0);
        capture("t2_clear");
        readout("t2_clear");

        build(2, 2, 0, 8, 1, 0);
        capture("flush_edge8");
        readout("flush_edge8");

        build(2, 2, 1, 9, 1, 0);
        capture("flush_late9");
        readout("flush_late9");

        src_q.delete();
        for (int i = 0; i < 300; i++) src_q.push_back(DW'($urandom));
        build(1, 1, 0, 0, 0, 0);
        capture("overrun");
        readout("overrun");

        src_q.delete();
        src_q.push_back(13'h0FFF);
        src_q.push_back(13'h1000);
        src_q.push_back(13'h0000);
        src_q.push_back(13'h0FFE);
        build(1, 2, 0, 2, 0, 0);
        capture("sat");
        readout("sat");

        src_q.delete();
        build(1, 1, 0, 4, 0, 0);
        capture("empty");
        readout("empty");

        seq_src(12);
        build(1, 2, 1, 0, 0, 1);
        capture("rearm");
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm.done_cleared", 32'(done), 32'd0);
        check("rearm.count_cleared", 32'(word_count), 32'd0);
        check("rearm.clear_cleared", 32'(clear_seen), 32'd0);
        seq_src(7);
        build(2, 1, 0, 5, 1, 0);
        capture("rearm2");
        readout("rearm2");

        seq_src(20);
        build(1, 1, 0, 0, 0, 0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        play(25);
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        play(len);
        repeat (12) step();
        check("midrst.ignored_done", 32'(done), 32'd0);
        check("midrst.ignored_count", 32'(word_count), 32'd0);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("midrst.rd_valid", 32'(rd_valid), 32'd0);

        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(0, 40);
            src_q.delete();
            for (int i = 0; i < n; i++) begin
                int sel;
                sel = $urandom_range(0, 7);
                if (sel == 0) src_q.push_back(13'h0FFF);
                else if (sel == 1) src_q.push_back(13'h1000);
                else src_q.push_back(DW'($urandom));
            end
            build($urandom_range(1, 2), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            capture($sformatf("rand%0d", s));
            readout($sformatf("rand%0d", s));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
